fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register. Sits between the PC register and decode.
- Takes the current `pc` and issues a request to instruction memory, which may have variable latency.
- Captures the returned word into the IF/ID register and supplies decode with `fd_Inst`, `fd_Inst_25_0`, `fd_br_signext_sl2` and `fd_pc_plus_4`.
- Drives `f_stall`. The hazard unit ORs `f_stall` into `d_stall`, which freezes the PC and the front end while memory is busy.

---
 rtl/mips_pkg.sv | 11 +
 rtl/fetch_skid.sv | 31 +++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS front end.
package mips_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic F_REQ = 1'b0;
  localparam logic F_HOLD = 1'b1;
  localparam int IMM_MSB = 15;
  localparam int TARGET_MSB = 25;
  function automatic logic [31:0] br_offset(input logic [31:0] inst);
    return {{(29 - IMM_MSB){inst[IMM_MSB]}}, inst[IMM_MSB:0], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for a fetched word acked while decode is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4,
  output logic        o_full
);
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_inst <= '0;
      r_pc4  <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_inst <= i_inst;
      r_pc4  <= i_pc4;
      r_full <= 1'b1;
    end
  assign o_inst = r_inst;
  assign o_pc4  = r_pc4;
  assign o_full = r_full;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: variable-latency instruction fetch with IF/ID register and skid buffer.
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        d_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        f_stall,
  output logic [31:0] fd_Inst,
  output logic        fd_valid,
  output logic [31:0] fd_pc_plus_4,
  output logic [25:0] fd_Inst_25_0,
  output logic [31:0] fd_br_signext_sl2
);
  logic        r_state;
  logic [31:0] r_inst;
  logic        r_valid;
  logic [31:0] r_pc4;
  logic [31:0] w_pc4;
  logic [31:0] w_sk_inst;
  logic [31:0] w_sk_pc4;
  logic        w_sk_full;
  logic        w_in_req;
  logic        w_take;
  logic        w_park;
  logic        w_drain;
  logic        w_unused_pc;
  assign w_unused_pc = ^pc[1:0];
  assign imem_addr = {pc[31:2], 2'b00};
  assign w_pc4     = imem_addr + 32'd4;
  assign w_in_req  = (r_state == F_REQ);
  assign w_take    = w_in_req & imem_ack & ~d_stall;
  assign w_park    = w_in_req & imem_ack & d_stall;
  assign w_drain   = (r_state == F_HOLD) & w_sk_full & ~d_stall;
  // rst gates the request so it drops while reset is held, not just after the edge
  assign imem_req  = rst & w_in_req;
  assign f_stall   = rst & w_in_req & ~imem_ack;
  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_park & ~flush),
    .i_clear (flush | w_drain),
    .i_inst  (imem_rdata),
    .i_pc4   (w_pc4),
    .o_inst  (w_sk_inst),
    .o_pc4   (w_sk_pc4),
    .o_full  (w_sk_full)
  );
  // flush outranks capture: an ack in the flush cycle is dropped and refetched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= F_REQ;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_pc4   <= '0;
    end else if (flush) begin
      r_state <= F_REQ;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_inst  <= imem_rdata;
      r_valid <= 1'b1;
      r_pc4   <= w_pc4;
    end else if (w_park) begin
      r_state <= F_HOLD;
    end else if (w_drain) begin
      r_state <= F_REQ;
      r_inst  <= w_sk_inst;
      r_valid <= 1'b1;
      r_pc4   <= w_sk_pc4;
    end
  assign fd_Inst           = r_inst;
  assign fd_valid          = r_valid;
  assign fd_pc_plus_4      = r_pc4;
  assign fd_Inst_25_0      = r_inst[TARGET_MSB:0];
  assign fd_br_signext_sl2 = br_offset(r_inst);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic checked against a pending-word model of the front end.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hz = 1'b0;
  logic        flush = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        d_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        f_stall;
  logic [31:0] fd_Inst;
  logic        fd_valid;
  logic [31:0] fd_pc_plus_4;
  logic [25:0] fd_Inst_25_0;
  logic [31:0] fd_br_signext_sl2;
  int checks = 0;
  int fails = 0;
  logic        pend_v;
  logic [31:0] pend_w;
  logic [31:0] pend_p4;
  logic [31:0] m_inst;
  logic        m_valid;
  logic [31:0] m_p4;
  logic [31:0] pc_nx;

  always #5 clk = ~clk;
  assign d_stall = hz | f_stall;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .d_stall(d_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .f_stall(f_stall), .fd_Inst(fd_Inst),
    .fd_valid(fd_valid), .fd_pc_plus_4(fd_pc_plus_4),
    .fd_Inst_25_0(fd_Inst_25_0), .fd_br_signext_sl2(fd_br_signext_sl2)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8C01_0004;
      32'h4:   return 32'h8C02_0008;
      32'h8:   return 32'h0022_1820;
      32'h40:  return 32'h1000_FFFF;
      32'h44:  return 32'h0C12_3456;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic mreset();
    pend_v = 1'b0;
    m_inst = 32'h0;
    m_valid = 1'b0;
    m_p4 = 32'h0;
  endtask

  // One cycle: drive at negedge, compare settled outputs, advance the model to the next edge.
  task automatic step(input logic h, input logic f, input logic a, input logic redirect);
    logic e_req, e_fst, dst;
    logic [31:0] aa, w;
    @(negedge clk);
    pc = pc_nx;
    hz = h;
    flush = f;
    imem_ack = a & imem_req;
    aa = {pc[31:2], 2'b00};
    w = mem(aa);
    imem_rdata = imem_ack ? w : $urandom;
    #1;
    e_req = !pend_v;
    e_fst = e_req && !imem_ack;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    chk("f_stall", {31'b0, f_stall}, {31'b0, e_fst});
    if (e_req) chk("imem_addr", imem_addr, aa);
    chk("fd_Inst", fd_Inst, m_inst);
    chk("fd_valid", {31'b0, fd_valid}, {31'b0, m_valid});
    chk("fd_pc_plus_4", fd_pc_plus_4, m_p4);
    chk("fd_Inst_25_0", {6'b0, fd_Inst_25_0}, {6'b0, m_inst[25:0]});
    chk("fd_br_signext_sl2", fd_br_signext_sl2, {{14{m_inst[15]}}, m_inst[15:0], 2'b00});
    dst = h | e_fst;
    if (f) begin
      m_inst = 32'h0;
      m_valid = 1'b0;
      pend_v = 1'b0;
    end else if (!pend_v && imem_ack) begin
      if (!dst) begin
        m_inst = w;
        m_valid = 1'b1;
        m_p4 = aa + 32'd4;
      end else begin
        pend_v = 1'b1;
        pend_w = w;
        pend_p4 = aa + 32'd4;
      end
    end else if (pend_v && !dst) begin
      m_inst = pend_w;
      m_valid = 1'b1;
      m_p4 = pend_p4;
      pend_v = 1'b0;
    end
    pc_nx = (f && redirect) ? $urandom : (dst ? pc : pc + 32'd4);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mreset();
    pc_nx = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_f_stall", {31'b0, f_stall}, 32'h0);
    chk("rst_fd_Inst", fd_Inst, 32'h0);
    chk("rst_fd_valid", {31'b0, fd_valid}, 32'h0);
    chk("rst_fd_pc4", fd_pc_plus_4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    // zero-wait memory: one word per cycle, one cycle behind pc
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("zw_inst0", fd_Inst, 32'h8C01_0004);
    chk("zw_pc4_0", fd_pc_plus_4, 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("zw_inst2", fd_Inst, 32'h0022_1820);
    chk("zw_pc4_2", fd_pc_plus_4, 32'd12);
    chk("zw_valid", {31'b0, fd_valid}, 32'h1);
    // three-cycle ack latency at 0x40
    pc_nx = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("wait_f_stall", {31'b0, f_stall}, 32'h1);
      chk("wait_addr", imem_addr, 32'h40);
      chk("wait_inst_held", fd_Inst, 32'h0022_1820);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("lat_inst", fd_Inst, 32'h1000_FFFF);
    chk("lat_br", fd_br_signext_sl2, 32'hFFFF_FFFC);
    chk("lat_t25", {6'b0, fd_Inst_25_0}, 32'h000_FFFF);
    chk("lat_pc4", fd_pc_plus_4, 32'h44);
    // ack under stall parks in the skid until the stall falls
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("skid_req_low", {31'b0, imem_req}, 32'h0);
    chk("skid_inst_held", fd_Inst, 32'h1000_FFFF);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("skid_inst", fd_Inst, 32'h0C12_3456);
    chk("skid_t25", {6'b0, fd_Inst_25_0}, 32'h012_3456);
    chk("skid_pc4", fd_pc_plus_4, 32'h48);
    // flush while holding a parked word
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("flush_inst", fd_Inst, 32'h0);
    chk("flush_valid", {31'b0, fd_valid}, 32'h0);
    chk("flush_req", {31'b0, imem_req}, 32'h1);
    chk("flush_pc4_kept", fd_pc_plus_4, 32'h48);
    // reset while a fetch is outstanding
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_req", {31'b0, imem_req}, 32'h0);
    chk("mrst_f_stall", {31'b0, f_stall}, 32'h0);
    chk("mrst_inst", fd_Inst, 32'h0);
    chk("mrst_pc4", fd_pc_plus_4, 32'h0);
    mreset();
    pc_nx = 32'h100;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("restart_pc4", fd_pc_plus_4, 32'h104);
    // pc+4 wraps and the word-offset bits are ignored
    pc_nx = 32'hFFFF_FFFE;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("wrap_pc4", fd_pc_plus_4, 32'h0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
